mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): BURST_LEN, 4, words per line transfer (power of 2, 2..16).
REQ-002 ADDR_W, 32, byte address width.
REQ-003 BW, log2(BURST_LEN), beat index width.
REQ-004 Ports (name, direction, width, meaning): MEM_CLK, in, 1, single clock; all state updates on the rising edge.
REQ-005 MEM_RST_N, in, 1, asynchronous active-low reset.
REQ-006 IC_REQ / DC_REQ, in, 1, instruction / data cache line-transfer request, held until DONE.
REQ-007 IC_WE / DC_WE, in, 1, 1 = line writeback, 0 = line fill.
REQ-008 IC_ADDR / DC_ADDR, in, ADDR_W, line byte address.
REQ-009 IC_WDATA / DC_WDATA, in, 32, write word for the beat given by WIDX.
REQ-010 IC_DONE / DC_DONE, out, 1, one-cycle transaction-complete pulse.
REQ-011 BVALID, out, 1, registered beat strobe to the granted requester.
REQ-012 BEAT, out, BW, registered index of the BVALID beat.
REQ-013 RDATA, out, 32, registered fill word, valid with BVALID.
REQ-014 WIDX, out, BW, combinational current write-beat index.
REQ-015 GNT_DC, out, 1, 1 = DC owns the memory port, 0 = IC or idle.
REQ-016 RE / WE, out, 1, memory read / write enable.
REQ-017 ADDR, out, ADDR_W, memory line address.
REQ-018 DATA_IN, out, 32, memory write data.
REQ-019 DATA_OUT, in, 32, memory read data.
REQ-020 MEMVALID, in, 1, memory beat complete.
REQ-021 ERR, out, 1, sticky protocol-error flag.

Function
REQ-022 FSM states: IDLE, BUSY and DONE; DONE always returns to IDLE on the next cycle.
REQ-023 REQ is sampled only in IDLE; any REQ high moves the FSM to BUSY on the next edge.
REQ-024 On that edge the block latches owner, WE and ADDR, with ADDR bits [BW+1:0] forced to 0.
REQ-025 Arbitration is round-robin: when both REQ are high in IDLE, the requester other than last_grant wins.
REQ-026 When a single REQ is high, that requester wins regardless of last_grant; last_grant updates on every grant.
REQ-027 In BUSY, RE = ~WE_latched and WE = WE_latched, held level for every BUSY cycle; both are 0 in IDLE and DONE.
REQ-028 ADDR holds the latched line address for the whole of BUSY.
REQ-029 The beat counter clears on grant and increments on each MEMVALID in BUSY, wrapping at BURST_LEN-1.
REQ-030 WIDX equals the beat counter; DATA_IN is the owner's WDATA, combinational.
REQ-031 Each MEMVALID in BUSY produces, next cycle: BVALID=1, BEAT=counter, RDATA=DATA_OUT (RDATA held for writes).
REQ-032 MEMVALID with counter = BURST_LEN-1 moves the FSM to DONE; in DONE the owner's DONE = 1 for exactly one cycle.
REQ-033 The last BVALID and DONE coincide; the requester drops REQ at the next edge.
REQ-034 End-to-end latency is 1 cycle grant + memory latency + 1 cycle DONE; there is no timeout.
REQ-035 A new grant is possible 1 cycle after DONE (IDLE), giving a minimum 1-cycle RE/WE gap between transactions.
REQ-036 REQ changes during BUSY or DONE are ignored; the owner's address and WE are not re-sampled.
REQ-037 MEMVALID in IDLE or DONE sets ERR (sticky) and is otherwise ignored.
REQ-038 GNT_DC reflects the owner during BUSY and DONE and is 0 in IDLE.

Reset
REQ-039 Asserting MEM_RST_N low immediately forces the FSM to IDLE, counter = 0 and last_grant = DC.
REQ-040 Asserting MEM_RST_N low immediately forces outputs RE, WE, BVALID, IC_DONE, DC_DONE, GNT_DC and ERR to 0.
REQ-041 Asserting MEM_RST_N low immediately forces outputs ADDR, RDATA and BEAT to 0.
REQ-042 Reset during BUSY aborts the transfer; no DONE is issued, and the requester re-requests.
REQ-043 Release of reset is synchronised internally; the first grant is possible 2 cycles after deassertion.

Verification
REQ-044 IC_REQ fill at 0x0000_1234, memory DELAY 10, BURST 4 -> ADDR=0x0000_1230, RE high 14 cycles, BEATs 0..3 carry DATA_OUT, IC_DONE with BEAT=3.
REQ-045 IC and DC requests in the same IDLE cycle after reset -> IC granted first; DC granted 1 cycle after IC_DONE; GNT_DC=1 only during DC BUSY/DONE.
REQ-046 DC writeback at 0x40, WDATA=0xA0+WIDX -> DATA_IN sequence 0xA0..0xA3 at each MEMVALID, WE=1, RE=0, DC_DONE pulse.
REQ-047 Back-to-back DC requests with IC continuously requesting -> strict IC/DC alternation, no starvation.
REQ-048 Spurious MEMVALID in IDLE -> ERR=1 and stays 1; no BVALID, no DONE.
REQ-049 MEM_RST_N pulled low on beat 2 of a fill -> RE=0 immediately, no DONE; after release a new request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IC/DC arbiter for a single burst memory port
module mem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32,
  parameter int BW        = $clog2(BURST_LEN)
) (
  input  logic              MEM_CLK,
  input  logic              MEM_RST_N,
  input  logic              IC_REQ,
  input  logic              IC_WE,
  input  logic [ADDR_W-1:0] IC_ADDR,
  input  logic [31:0]       IC_WDATA,
  output logic              IC_DONE,
  input  logic              DC_REQ,
  input  logic              DC_WE,
  input  logic [ADDR_W-1:0] DC_ADDR,
  input  logic [31:0]       DC_WDATA,
  output logic              DC_DONE,
  output logic              BVALID,
  output logic [BW-1:0]     BEAT,
  output logic [31:0]       RDATA,
  output logic [BW-1:0]     WIDX,
  output logic              GNT_DC,
  output logic              RE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [31:0]       DATA_IN,
  input  logic [31:0]       DATA_OUT,
  input  logic              MEMVALID,
  output logic              ERR
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic              owner_dc;
  logic              we_l;
  logic              last_dc;
  logic [BW-1:0]     cnt;
  logic              pick_dc;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic              last_beat;

  // The requester that did not win last time has priority when both ask.
  always_comb begin
    pick_dc   = DC_REQ && (!IC_REQ || !last_dc);
    pick_we   = pick_dc ? DC_WE : IC_WE;
    pick_addr = pick_dc ? DC_ADDR : IC_ADDR;
    last_beat = (cnt == BW'(BURST_LEN - 1));
  end

  assign WIDX    = cnt;
  assign DATA_IN = owner_dc ? DC_WDATA : IC_WDATA;

  // Reset assertion is immediate; release is held off two edges before grants start.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      state    <= IDLE;
      owner_dc <= 1'b0;
      we_l     <= 1'b0;
      last_dc  <= 1'b1;
      cnt      <= '0;
      RE       <= 1'b0;
      WE       <= 1'b0;
      ADDR     <= '0;
      GNT_DC   <= 1'b0;
      BVALID   <= 1'b0;
      BEAT     <= '0;
      RDATA    <= '0;
      IC_DONE  <= 1'b0;
      DC_DONE  <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      BVALID  <= 1'b0;
      IC_DONE <= 1'b0;
      DC_DONE <= 1'b0;
      if (MEMVALID && state != BUSY) ERR <= 1'b1;
      case (state)
        IDLE: begin
          if (rst_sync[1] && (IC_REQ || DC_REQ)) begin
            state    <= BUSY;
            owner_dc <= pick_dc;
            last_dc  <= pick_dc;
            GNT_DC   <= pick_dc;
            we_l     <= pick_we;
            RE       <= !pick_we;
            WE       <= pick_we;
            ADDR     <= {pick_addr[ADDR_W-1:BW+2], {(BW+2){1'b0}}};
            cnt      <= '0;
          end
        end
        BUSY: begin
          if (MEMVALID) begin
            BVALID <= 1'b1;
            BEAT   <= cnt;
            if (!we_l) RDATA <= DATA_OUT;
            cnt <= cnt + BW'(1);
            if (last_beat) begin
              state   <= DONE;
              RE      <= 1'b0;
              WE      <= 1'b0;
              IC_DONE <= !owner_dc;
              DC_DONE <= owner_dc;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          GNT_DC <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
